// File: rtl/ram_interface_pkg.sv
// Shared encodings and default widths for the core-to-SRAM bridge.
package ram_interface_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_SETUP  = 2'b01;
  localparam state_t ST_ACCESS = 2'b10;
  localparam state_t ST_HOLD   = 2'b11;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/ram_interface_wait_counter.sv
// Loadable down-counter that times the ACCESS phase; stops at zero.
module wait_counter
  import ram_interface_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram_interface.sv
// Core byte port to async SRAM bridge: SETUP, ACCESS (WAIT_CYCLES+1), HOLD.
module ram_interface
  import ram_interface_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  wait_counter #(.W(CNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (WAIT_LD),
    .zero_o     (cnt_zero)
  );

  // Next-state and next-output logic; every output is registered so each
  // value below is what the pins show in the state being entered.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_data_d   = rd_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    ce_d        = ce_q;
    done_d      = 1'b0;
    oe_d        = 1'b0;
    we_d        = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d      = 1'b0;
        ce_d        = 1'b0;
        mem_wdata_d = '0;
        if (rd_req || wr_req) begin
          // Read wins a tie; the write is dropped.
          state_d     = ST_SETUP;
          op_d        = rd_req ? OP_RD : OP_WR;
          mem_addr_d  = addr_in;
          mem_wdata_d = rd_req ? '0 : wr_data;
          busy_d      = 1'b1;
          ce_d        = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        cnt_load = 1'b1;
        oe_d     = (op_q == OP_RD);
        we_d     = (op_q == OP_WR);
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          done_d  = 1'b1;
          if (op_q == OP_RD) rd_data_d = mem_rdata;
        end else begin
          cnt_dec = 1'b1;
          oe_d    = (op_q == OP_RD);
          we_d    = (op_q == OP_WR);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        ce_d        = 1'b0;
        mem_wdata_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RD;
      rd_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ce_q        <= 1'b0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_data_q   <= rd_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ce_q        <= ce_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ce    = ce_q;
  assign mem_oe    = oe_q;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_ram_interface.sv
// Scoreboard bench: transaction-timing reference model, SRAM model, monitor.
module tb_ram_interface;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] addr_in = '0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_data, mem_wdata, mem_rdata;
  logic [14:0] mem_addr;
  logic        busy, done, mem_ce, mem_oe, mem_we;

  // Zero-wait-state instance, exercised by a short directed sequence.
  logic [14:0] addr0 = '0;
  logic        rd_req0 = 1'b0, wr_req0 = 1'b0;
  logic [7:0]  wr_data0 = '0, mem_rdata0 = '0;
  logic [7:0]  rd_data0, mem_wdata0;
  logic [14:0] mem_addr0;
  logic        busy0, done0, mem_ce0, mem_oe0, mem_we0;

  always #5 clk = ~clk;

  ram_interface #(.ADDR_W(15), .DATA_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .rd_req(rd_req), .wr_req(wr_req),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we)
  );

  ram_interface #(.ADDR_W(15), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .addr_in(addr0), .rd_req(rd_req0), .wr_req(wr_req0),
    .wr_data(wr_data0), .rd_data(rd_data0), .busy(busy0), .done(done0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
    .mem_ce(mem_ce0), .mem_oe(mem_oe0), .mem_we(mem_we0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [14:0] a);
    if (a == 15'h1234) return 8'hA5;
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h6C;
  endfunction

  // Physical SRAM seen through the DUT pins.
  logic [7:0] phys   [0:32767];
  bit         phys_v [0:32767];
  always @(posedge clk)
    if (mem_we) begin
      phys[mem_addr]   <= mem_wdata;
      phys_v[mem_addr] <= 1'b1;
    end
  assign mem_rdata = phys_v[mem_addr] ? phys[mem_addr] : init_byte(mem_addr);

  // Reference model: a transaction sampled at edge E occupies cycles E..E+W+2
  // (busy/ce), strobes oe/we in E+1..E+W+1, pulses done in E+W+2, and the
  // next request can be taken at edge E+W+4.
  typedef struct {
    logic        op;
    logic [14:0] addr;
    int          done_cyc;
    logic [7:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem[int];
  int          cyc = 0, free_cyc = 0, mE = 0;
  bit          has = 0;
  logic        m_op = 1'b0;
  logic [14:0] m_addr = '0, last_addr = '0;
  logic [7:0]  m_wdata = '0, ref_rd = '0;

  function automatic logic [7:0] ref_byte(input logic [14:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (has && m_op && cyc == mE + 2) ref_mem[int'(m_addr)] = m_wdata;
    if (rst) begin
      has = 0; ref_rd = '0; last_addr = '0; sb.delete(); free_cyc = cyc + 1;
    end else begin
      if (has && !m_op && cyc == mE + W + 2) ref_rd = ref_byte(m_addr);
      if (cyc >= free_cyc && (rd_req || wr_req)) begin
        has = 1; mE = cyc; m_op = !rd_req; m_addr = addr_in;
        m_wdata = wr_data; last_addr = addr_in; free_cyc = cyc + W + 4;
        sb.push_back('{m_op, addr_in, cyc + W + 2, m_op ? ref_rd : ref_byte(addr_in)});
      end
    end
  end

  // Monitor: per-cycle pin expectations plus scoreboard pop on done.
  always @(negedge clk) begin
    if (cyc > 0) begin
      bit in_t;
      exp_t e;
      in_t = has && cyc >= mE && cyc <= mE + W + 2;
      chk("busy",      {31'b0, busy},   {31'b0, in_t});
      chk("mem_ce",    {31'b0, mem_ce}, {31'b0, in_t});
      chk("mem_oe",    {31'b0, mem_oe}, {31'b0, in_t && !m_op && cyc >= mE + 1 && cyc <= mE + W + 1});
      chk("mem_we",    {31'b0, mem_we}, {31'b0, in_t &&  m_op && cyc >= mE + 1 && cyc <= mE + W + 1});
      chk("done",      {31'b0, done},   {31'b0, in_t && cyc == mE + W + 2});
      chk("mem_addr",  {17'b0, mem_addr},  {17'b0, last_addr});
      chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, (in_t && m_op) ? m_wdata : 8'h00});
      chk("rd_data",   {24'b0, rd_data},   {24'b0, ref_rd});
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done: got done with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_latency", cyc, e.done_cyc);
          chk("sb_rd_data", {24'b0, rd_data}, {24'b0, e.rd});
          chk("sb_addr", {17'b0, mem_addr}, {17'b0, e.addr});
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input bit r, input bit w, input logic [14:0] a, input logic [7:0] d);
    rd_req = r; wr_req = w; addr_in = a; wr_data = d;
    step();
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  logic [14:0] addr_set [0:6];

  initial begin
    addr_set[0] = 15'h1234; addr_set[1] = 15'h0007; addr_set[2] = 15'h7FFF;
    addr_set[3] = 15'h0000; addr_set[4] = 15'h0001; addr_set[5] = 15'h0002;
    addr_set[6] = 15'h0003;

    step(3);
    rst = 1'b0;
    step(2);

    // Directed: read, write, tie, held request.
    req(1'b1, 1'b0, 15'h1234, 8'h00);  step(W + 5);
    chk("dir_read_a5", {24'b0, rd_data}, 32'hA5);
    req(1'b0, 1'b1, 15'h0007, 8'h3C);  step(W + 5);
    chk("dir_write_keeps_rd", {24'b0, rd_data}, 32'hA5);
    req(1'b1, 1'b1, 15'h7FFF, 8'hEE);  step(W + 5);
    req(1'b1, 1'b0, 15'h0007, 8'h00);  step(W + 5);
    chk("dir_readback_3c", {24'b0, rd_data}, 32'h3C);
    rd_req = 1'b1; addr_in = 15'h1234;
    step(11);
    rd_req = 1'b0;
    step(W + 5);

    // Reset during the second ACCESS cycle of a read.
    req(1'b1, 1'b0, 15'h0055, 8'h00);
    step(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_rd_data", {24'b0, rd_data}, 32'h0);
    step(4);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      rd_req  = ($urandom_range(0, 15) < 3);
      wr_req  = ($urandom_range(0, 15) < 3);
      addr_in = addr_set[$urandom_range(0, 6)];
      wr_data = 8'($urandom);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rd_req = 1'b0; wr_req = 1'b0; rst = 1'b0;
    step(W + 6);
    chk("sb_drained", sb.size(), 0);

    // Zero-wait-state build: done in relative cycle 3, one oe cycle.
    begin
      int oe_n, done_at;
      oe_n = 0; done_at = -1;
      rd_req0 = 1'b1; addr0 = 15'h0ABC; mem_rdata0 = 8'h5A;
      @(posedge clk); #1;
      rd_req0 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (mem_oe0) oe_n++;
        if (done0 && done_at < 0) done_at = k;
        if (k == 4) chk("w0_busy_after", {31'b0, busy0}, 32'h0);
      end
      chk("w0_latency", done_at, 3);
      chk("w0_oe_cycles", oe_n, 1);
      chk("w0_rd_data", {24'b0, rd_data0}, 32'h5A);
      chk("w0_addr", {17'b0, mem_addr0}, 32'h0ABC);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
